seg7_sequence_monitor: RTL and testbench



---
 rtl/seg7_sequence_monitor.sv | 122 ++++++++++++
 tb/tb_seg7_sequence_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_sequence_monitor.sv
// Receive-side checker for an active-low 7-segment bus: glitch filter, decode, up-count check.
// Latency: oValid one cycle after the STABLE_CYCLES-th repeated sample; always ready, never stalls.
module seg7_sequence_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MOD           = 8,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             iEn,
  input  logic [6:0]       iSeg,
  output logic             oValid,
  output logic [3:0]       oDigit,
  output logic             oIllegal,
  output logic             oSeqErr,
  output logic             oLocked,
  output logic [ERR_W-1:0] oErrCnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [6:0]  sample_q;
  logic        sample_vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  last_q;
  logic        last_vld_q;
  logic [3:0]  ref_q, ref_d;
  logic [3:0]  dec_digit;
  logic [3:0]  exp_digit;
  logic        same;
  logic        accept;
  logic        ill_d, seq_d;

  function automatic logic [3:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 4'd0;
      7'b1111001: decode = 4'd1;
      7'b0100100: decode = 4'd2;
      7'b0110000: decode = 4'd3;
      7'b0011001: decode = 4'd4;
      7'b0010010: decode = 4'd5;
      7'b0000010: decode = 4'd6;
      7'b1111000: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0010000: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  // The first enabled sample after reset or a disabled stretch always starts a fresh count.
  assign same      = sample_vld_q && (iSeg == sample_q);
  assign dec_digit = decode(iSeg);
  assign exp_digit = (ref_q == 4'(MOD - 1)) ? 4'd0 : ref_q + 4'd1;

  always_comb begin
    cnt_d = '0;
    if (iEn && same) begin
      if (cnt_q == CW'(STABLE_CYCLES)) cnt_d = cnt_q;
      else                             cnt_d = cnt_q + CW'(1);
    end
  end

  assign accept = iEn && same && (cnt_d == CW'(STABLE_CYCLES)) &&
                  (!last_vld_q || (iSeg != last_q));

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (accept) begin
      if (dec_digit == 4'hF) begin
        ill_d   = 1'b1;
        state_d = UNLOCKED;
      end else if (state_q == UNLOCKED) begin
        state_d = LOCKED;
        ref_d   = dec_digit;
      end else begin
        seq_d = (dec_digit != exp_digit);
        ref_d = dec_digit;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      cnt_q        <= '0;
      last_q       <= '0;
      last_vld_q   <= 1'b0;
      ref_q        <= '0;
      oValid       <= 1'b0;
      oDigit       <= '0;
      oIllegal     <= 1'b0;
      oSeqErr      <= 1'b0;
      oLocked      <= 1'b0;
      oErrCnt      <= '0;
    end else begin
      if (iEn) sample_q <= iSeg;
      sample_vld_q <= iEn;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      ref_q        <= ref_d;
      oValid       <= accept;
      oIllegal     <= ill_d;
      oSeqErr      <= seq_d;
      oLocked      <= (state_d == LOCKED);
      if (accept) begin
        last_q     <= iSeg;
        last_vld_q <= 1'b1;
        oDigit     <= dec_digit;
      end
      if ((ill_d || seq_d) && (oErrCnt != '1)) oErrCnt <= oErrCnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// Directed bench for seg7_sequence_monitor; a second instance with ERR_W=2 covers saturation.
module tb_seg7_sequence_monitor;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       iEn = 1'b1;
  logic [6:0] iSeg = 7'b1111111;

  logic       oValid, oIllegal, oSeqErr, oLocked;
  logic [3:0] oDigit;
  logic [7:0] oErrCnt;
  logic       v2, ill2, seq2, lock2;
  logic [3:0] dig2;
  logic [1:0] err2;

  int checks = 0;
  int passed = 0;
  int vcnt   = 0;
  logic [3:0] cap_digit;
  logic       cap_ill, cap_seq;

  always #5 CLK = ~CLK;

  seg7_sequence_monitor #(.STABLE_CYCLES(4), .MOD(8), .ERR_W(8)) dut (
    .CLK(CLK), .rst(rst), .iEn(iEn), .iSeg(iSeg),
    .oValid(oValid), .oDigit(oDigit), .oIllegal(oIllegal), .oSeqErr(oSeqErr),
    .oLocked(oLocked), .oErrCnt(oErrCnt)
  );

  seg7_sequence_monitor #(.STABLE_CYCLES(4), .MOD(8), .ERR_W(2)) dut2 (
    .CLK(CLK), .rst(rst), .iEn(iEn), .iSeg(iSeg),
    .oValid(v2), .oDigit(dig2), .oIllegal(ill2), .oSeqErr(seq2),
    .oLocked(lock2), .oErrCnt(err2)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Drive a pattern for n edges (called at a negedge), sampling outputs on each following negedge.
  task automatic hold(input logic [6:0] seg, input int n);
    iSeg = seg;
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      if (oValid) begin
        vcnt++;
        cap_digit = oDigit;
        cap_ill   = oIllegal;
        cap_seq   = oSeqErr;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({oValid, oDigit, oIllegal, oSeqErr, oLocked, oErrCnt} !== 16'h0)
      $display("FAIL reset_outputs: got %h want 0", {oValid, oDigit, oIllegal, oSeqErr, oLocked, oErrCnt});
    else passed++;
    checks++;
    if ({v2, dig2, ill2, seq2, lock2, err2} !== 10'h0)
      $display("FAIL reset_outputs_w2: got %h want 0", {v2, dig2, ill2, seq2, lock2, err2});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_count();
    int v0;
    pulse_reset();
    iEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v0 = vcnt;
      hold(seg_of(i % 8), 6);
      checks++;
      if (vcnt !== v0 + 1 || cap_digit !== 4'(i % 8) || cap_seq !== 1'b0)
        $display("FAIL count_step%0d: pulses=%0d digit=%0d seqerr=%0b want pulses=1 digit=%0d seqerr=0",
                 i, vcnt - v0, cap_digit, cap_seq, i % 8);
      else passed++;
      checks++;
      if (oLocked !== 1'b1) $display("FAIL count_locked%0d: got %0b want 1", i, oLocked);
      else passed++;
    end
    checks++;
    if (oErrCnt !== 8'd0) $display("FAIL count_errcnt: got %0d want 0", oErrCnt);
    else passed++;
  endtask

  task automatic test_glitch();
    int v0;
    hold(seg_of(2), 6);
    checks++;
    if (cap_digit !== 4'd2 || cap_seq !== 1'b0)
      $display("FAIL glitch_pre: digit=%0d seqerr=%0b want 2/0", cap_digit, cap_seq);
    else passed++;
    v0 = vcnt;
    hold(7'b0000000, 3);
    hold(seg_of(2), 6);
    checks++;
    if (vcnt !== v0) $display("FAIL glitch_reject: got %0d extra pulses want 0", vcnt - v0);
    else passed++;
    hold(seg_of(3), 6);
    checks++;
    if (vcnt !== v0 + 1 || cap_digit !== 4'd3 || cap_seq !== 1'b0 || oErrCnt !== 8'd0)
      $display("FAIL glitch_next: pulses=%0d digit=%0d seqerr=%0b err=%0d want 1/3/0/0",
               vcnt - v0, cap_digit, cap_seq, oErrCnt);
    else passed++;
  endtask

  task automatic test_seq_error();
    pulse_reset();
    hold(seg_of(1), 6);
    hold(seg_of(2), 6);
    hold(seg_of(4), 6);
    checks++;
    if (cap_digit !== 4'd4 || cap_seq !== 1'b1 || oErrCnt !== 8'd1 || oLocked !== 1'b1)
      $display("FAIL seq_err: digit=%0d seqerr=%0b err=%0d locked=%0b want 4/1/1/1",
               cap_digit, cap_seq, oErrCnt, oLocked);
    else passed++;
    hold(seg_of(5), 6);
    checks++;
    if (cap_digit !== 4'd5 || cap_seq !== 1'b0 || oErrCnt !== 8'd1)
      $display("FAIL seq_resync: digit=%0d seqerr=%0b err=%0d want 5/0/1", cap_digit, cap_seq, oErrCnt);
    else passed++;
  endtask

  task automatic test_illegal();
    pulse_reset();
    hold(seg_of(3), 6);
    hold(7'b1111111, 6);
    checks++;
    if (cap_digit !== 4'hF || cap_ill !== 1'b1 || cap_seq !== 1'b0 || oErrCnt !== 8'd1 || oLocked !== 1'b0)
      $display("FAIL illegal: digit=%h ill=%0b seq=%0b err=%0d locked=%0b want f/1/0/1/0",
               cap_digit, cap_ill, cap_seq, oErrCnt, oLocked);
    else passed++;
    hold(seg_of(5), 6);
    checks++;
    if (cap_digit !== 4'd5 || cap_ill !== 1'b0 || cap_seq !== 1'b0 || oErrCnt !== 8'd1 || oLocked !== 1'b1)
      $display("FAIL relock: digit=%0d ill=%0b seq=%0b err=%0d locked=%0b want 5/0/0/1/1",
               cap_digit, cap_ill, cap_seq, oErrCnt, oLocked);
    else passed++;
  endtask

  task automatic test_saturate();
    int seqv [6] = '{0, 2, 5, 1, 4, 7};
    logic [1:0] exp2 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      hold(seg_of(seqv[i]), 6);
      checks++;
      if (err2 !== exp2[i]) $display("FAIL sat_step%0d: got %0d want %0d", i, err2, exp2[i]);
      else passed++;
    end
    checks++;
    if (oErrCnt !== 8'd5) $display("FAIL sat_wide: got %0d want 5", oErrCnt);
    else passed++;
  endtask

  task automatic test_reset_and_enable();
    int v0, found, npulse;
    pulse_reset();
    hold(seg_of(5), 6);
    v0 = vcnt;
    hold(seg_of(6), 2);
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({oValid, oDigit, oIllegal, oSeqErr, oLocked, oErrCnt} !== 16'h0 || vcnt !== v0)
      $display("FAIL midreset: got %h pulses=%0d want 0/0", {oValid, oDigit, oIllegal, oSeqErr, oLocked, oErrCnt}, vcnt - v0);
    else passed++;
    @(negedge CLK);
    rst = 1'b0;
    found = 0;
    npulse = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (oValid) begin
        npulse++;
        if (found == 0) found = i;
      end
    end
    checks++;
    if (found !== 5 || npulse !== 1 || oDigit !== 4'd6 || oLocked !== 1'b1)
      $display("FAIL post_reset_accept: edge=%0d pulses=%0d digit=%0d locked=%0b want 5/1/6/1",
               found, npulse, oDigit, oLocked);
    else passed++;
    iEn = 1'b0;
    v0 = vcnt;
    hold(seg_of(7), 8);
    checks++;
    if (vcnt !== v0 || oDigit !== 4'd6 || oLocked !== 1'b1)
      $display("FAIL disabled_hold: pulses=%0d digit=%0d locked=%0b want 0/6/1", vcnt - v0, oDigit, oLocked);
    else passed++;
    iEn = 1'b1;
    found = 0;
    npulse = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (oValid) begin
        npulse++;
        if (found == 0) found = i;
        checks++;
        if (oSeqErr !== 1'b0) $display("FAIL enable_seqerr: got %0b want 0", oSeqErr);
        else passed++;
      end
    end
    checks++;
    if (found !== 5 || npulse !== 1 || oDigit !== 4'd7)
      $display("FAIL enable_accept: edge=%0d pulses=%0d digit=%0d want 5/1/7", found, npulse, oDigit);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_glitch();
    test_seq_error();
    test_illegal();
    test_reset_and_enable();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
